store_buffer: RTL

Posted-write buffer between the processor core's data-memory write port and the data memory / memory-mapped I/O fabric. Captures each core store in the cycle it is issued, normalises it to a word-aligned address plus byte enables, and drains entries in order over a valid/ready port, so the core runs while the downstream side is slow. Asserts `Stall` back to the core when no entry is free.

---
 rtl/store_buffer.sv | 95 +++++++++
 1 files changed

// File: rtl/store_buffer.sv
// Posted-write buffer between the core store port and the memory/IO fabric.
// Stores are normalised to word address + byte enables and drained in FIFO order.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH+1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MemWrite,
    input  logic          ByteMem,
    input  logic [31:0]   DataAdr,
    input  logic [31:0]   WriteData,
    output logic          Stall,
    output logic          mem_valid,
    input  logic          mem_ready,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_be,
    output logic [CW-1:0] Count,
    output logic          Empty,
    output logic          Misalign
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [29:0]   addr_q  [DEPTH];
    logic [31:0]   wdata_q [DEPTH];
    logic [3:0]    be_q    [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          misalign_q;

    logic          full, push, pop;
    logic [31:0]   ent_wdata;
    logic [3:0]    ent_be;

    // Stall looks only at the registered count, so a pop in the same cycle
    // never lets a store through early.
    assign full  = (count_q == CW'(DEPTH));
    assign Stall = MemWrite & full;
    assign push  = MemWrite & ~full;
    assign pop   = (count_q != '0) & mem_ready;

    always_comb begin
        ent_wdata = WriteData;
        ent_be    = 4'b1111;
        if (ByteMem) begin
            ent_wdata = {4{WriteData[7:0]}};
            ent_be    = 4'b0001 << DataAdr[1:0];
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i]  <= '0;
                wdata_q[i] <= '0;
                be_q[i]    <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            if (push) begin
                addr_q[wr_ptr_q]  <= DataAdr[31:2];
                wdata_q[wr_ptr_q] <= ent_wdata;
                be_q[wr_ptr_q]    <= ent_be;
                wr_ptr_q          <= wr_ptr_q + PW'(1);
                if (~ByteMem && (DataAdr[1:0] != 2'b00))
                    misalign_q <= 1'b1;
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    // Head entry comes straight from registered storage: no input-to-output path.
    assign mem_valid = (count_q != '0);
    assign mem_addr  = {addr_q[rd_ptr_q], 2'b00};
    assign mem_wdata = wdata_q[rd_ptr_q];
    assign mem_be    = be_q[rd_ptr_q];
    assign Count     = count_q;
    assign Empty     = (count_q == '0);
    assign Misalign  = misalign_q;
endmodule
